packet_processor: RTL and testbench

Manchester-decoding Ethernet receive front end. It samples the serial line (a fixed number of clocks per half-bit), recovers bits from mid-bit transitions and locks onto the start-frame delimiter. It then assembles the following bits MSB-first into bytes and pushes each byte into the downstream receive FIFO with a single-cycle write strobe. It sits between the line input and the RX FIFO.

---
 rtl/packet_processor_if.sv | 11 +
 rtl/packet_processor.sv | 145 ++++++++++++++
 tb/tb_packet_processor.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/packet_processor_if.sv
// Line-side and RX-FIFO-side signals of the Manchester receive front end.
// The slave modport is the decoder; the master modport is the line/FIFO environment.
interface packet_processor_if;
  logic       Ethernet_In;
  logic       FULL;
  logic [7:0] E_Data;
  logic       w_enable;

  modport master (output Ethernet_In, output FULL, input E_Data, input w_enable);
  modport slave  (input Ethernet_In, input FULL, output E_Data, output w_enable);
endinterface

// File: rtl/packet_processor.sv
// Manchester receive front end: synchronise, recover mid-bit edges, hunt for the SFD, push bytes to the RX FIFO.
// Optional macro PP_HEADER_ONLY_EN: forward only bytes 6..13 after the SFD (SA and LEN).
module packet_processor #(
  parameter int HALF_BIT     = 5,
  parameter int BLANK        = 7,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  packet_processor_if.slave  bus
);

  // Headroom of one bit period past the timeout so saturation never masks it.
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 2 * HALF_BIT + 1);
  localparam logic [7:0] SFD = 8'hAB;

  typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, RECEIVE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               hist_q, hist_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         hunt_q, hunt_d;
  logic [7:0]         byte_q, byte_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         edata_q, edata_d;
  logic               wen_q, wen_d;

  logic               edge_det;
  logic               bit_val;
  logic               acc;
  logic               write_ok;
  logic [7:0]         hunt_shift;
  logic [7:0]         byte_shift;

  assign edge_det   = sync2_q ^ hist_q;
  assign bit_val    = sync2_q;
  assign acc        = edge_det && ((state_q == IDLE) || (cnt_q >= CNT_W'(BLANK)));
  assign hunt_shift = {hunt_q[6:0], bit_val};
  assign byte_shift = {byte_q[6:0], bit_val};

`ifdef PP_HEADER_ONLY_EN
  logic [3:0] idx_q, idx_d;
  assign write_ok = (idx_q >= 4'd6) && (idx_q <= 4'd13);
`else
  assign write_ok = 1'b1;
`endif

  always_comb begin
    sync1_d  = bus.Ethernet_In;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    state_d  = state_q;
    cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    hunt_d   = hunt_q;
    byte_d   = byte_q;
    bitcnt_d = bitcnt_q;
    edata_d  = edata_q;
    wen_d    = 1'b0;
`ifdef PP_HEADER_ONLY_EN
    idx_d    = idx_q;
`endif

    if (acc) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          hunt_d  = hunt_shift;
          state_d = HUNT;
        end
        HUNT: begin
          hunt_d = hunt_shift;
          if (hunt_shift == SFD) begin
            state_d  = RECEIVE;
            bitcnt_d = 3'd0;
            byte_d   = 8'h00;
`ifdef PP_HEADER_ONLY_EN
            idx_d    = 4'd0;
`endif
          end
        end
        RECEIVE: begin
          byte_d   = byte_shift;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            // Dropped bytes still advance the index so header positions stay aligned.
            if (!bus.FULL && write_ok) begin
              wen_d   = 1'b1;
              edata_d = byte_shift;
            end
`ifdef PP_HEADER_ONLY_EN
            if (idx_q != 4'hF) idx_d = idx_q + 4'd1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (cnt_q >= CNT_W'(IDLE_TIMEOUT)) begin
      state_d  = IDLE;
      hunt_d   = 8'h00;
      byte_d   = 8'h00;
      bitcnt_d = 3'd0;
`ifdef PP_HEADER_ONLY_EN
      idx_d    = 4'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      hist_q   <= 1'b1;
      cnt_q    <= '0;
      hunt_q   <= 8'h00;
      byte_q   <= 8'h00;
      bitcnt_q <= 3'd0;
      edata_q  <= 8'h00;
      wen_q    <= 1'b0;
`ifdef PP_HEADER_ONLY_EN
      idx_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      hunt_q   <= hunt_d;
      byte_q   <= byte_d;
      bitcnt_q <= bitcnt_d;
      edata_q  <= edata_d;
      wen_q    <= wen_d;
`ifdef PP_HEADER_ONLY_EN
      idx_q    <= idx_d;
`endif
    end
  end

  assign bus.E_Data   = edata_q;
  assign bus.w_enable = wen_q;

endmodule

// File: tb/tb_packet_processor.sv
// Directed bench for packet_processor: Manchester frames in, strobed bytes checked against a scoreboard queue.
module tb_packet_processor;

  localparam int HB = 5;
`ifdef PP_HEADER_ONLY_EN
  localparam int FRAME_N = 8;
  localparam int FULL_N  = 8;
  localparam int PART_N  = 3;
`else
  localparam int FRAME_N = 20;
  localparam int FULL_N  = 16;
  localparam int PART_N  = 9;
`endif

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  packet_processor_if bus();

  packet_processor dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  int         p0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  function automatic bit written(int idx);
`ifdef PP_HEADER_ONLY_EN
    return (idx >= 6) && (idx <= 13);
`else
    return idx >= 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (n_rst && bus.w_enable) begin
      pulses++;
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_strobe got E_Data=%h expected no strobe", bus.E_Data);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        checks++;
        assert (bus.E_Data === exp_b)
        else begin
          errors++;
          $error("FAIL byte_data got %h expected %h", bus.E_Data, exp_b);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic half(input logic v);
    bus.Ethernet_In = v;
    repeat (HB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.Ethernet_In = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int idx, input logic full);
    bus.FULL = full;
    if (!full && written(idx)) exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) begin
      half(~b[i]);
      half(b[i]);
    end
  endtask

  task automatic send_head();
    for (int i = 0; i < 7; i++) send_byte(8'hAA, -1, 1'b0);
    send_byte(8'hAB, -1, 1'b0);
  endtask

  task automatic send_frame(input logic full_data);
    send_head();
    for (int i = 0; i < 14; i++) send_byte(8'hFB, i, 1'b0);
    for (int i = 0; i < 4; i++)  send_byte(8'h0F, 14 + i, full_data);
    for (int i = 0; i < 2; i++)  send_byte(8'hFB, 18 + i, 1'b0);
    bus.FULL = 1'b0;
  endtask

  initial begin
    bus.Ethernet_In = 1'b1;
    bus.FULL        = 1'b0;
    n_rst           = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_edata", bus.E_Data, 8'h00);
    check("reset_wen", bus.w_enable, 1'b0);
    check("reset_state", dut.state_q, 0);
    n_rst = 1'b1;
    idle(20);

    // Clean frame
    p0 = pulses;
    send_frame(1'b0);
    idle(20);
    check("clean_count", pulses - p0, FRAME_N);
    check("clean_drained", exp_q.size(), 0);
    check("clean_state_idle", dut.state_q, 0);
    check("edata_hold", bus.E_Data, 8'hFB);

    // FULL during data bytes
    p0 = pulses;
    send_frame(1'b1);
    idle(20);
    check("full_count", pulses - p0, FULL_N);
    check("full_drained", exp_q.size(), 0);

    // Preamble without SFD
    p0 = pulses;
    for (int i = 0; i < 7; i++) send_byte(8'hAA, -1, 1'b0);
    check("nosfd_hunting", dut.state_q, 1);
    idle(40);
    check("nosfd_count", pulses - p0, 0);
    check("nosfd_state_idle", dut.state_q, 0);

    // Reset in the middle of SA
    p0 = pulses;
    send_head();
    for (int i = 0; i < 9; i++) send_byte(8'hFB, i, 1'b0);
    check("partial_count", pulses - p0, PART_N);
    n_rst = 1'b0;
    #1;
    check("midrst_edata", bus.E_Data, 8'h00);
    check("midrst_wen", bus.w_enable, 1'b0);
    check("midrst_state", dut.state_q, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    idle(20);
    p0 = pulses;
    send_frame(1'b0);
    idle(20);
    check("resend_count", pulses - p0, FRAME_N);
    check("resend_drained", exp_q.size(), 0);

    // Back-to-back frames
    p0 = pulses;
    send_frame(1'b0);
    idle(20);
    send_frame(1'b0);
    idle(20);
    check("b2b_count", pulses - p0, 2 * FRAME_N);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_state_idle", dut.state_q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
